// File: rtl/cache_pkg.sv
// Shared types, geometry and byte-lane helper for the direct-mapped data cache.
package cache_pkg;
  localparam int ADDRESS_LENGTH = 32;
  localparam int SETS           = 256;
  localparam int INDEX_BITS     = $clog2(SETS);
  localparam int TAG_BITS       = ADDRESS_LENGTH - INDEX_BITS - 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } cache_state_t;

  // Byte-enable for a store; sb outranks sh, which outranks sw.
  function automatic logic [3:0] lane_mask(input logic sb, input logic sh,
                                           input logic sw, input logic [1:0] off);
    if (sb)      lane_mask = 4'b0001 << off;
    else if (sh) lane_mask = off[1] ? 4'b1100 : 4'b0011;
    else if (sw) lane_mask = 4'b1111;
    else         lane_mask = 4'b0000;
  endfunction
endpackage

// File: rtl/cache_store.sv
// Valid/tag/data line storage: combinational read, byte-masked write, invalidate and flush.
module cache_store import cache_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] i_index,
  output logic                  o_valid,
  output logic [TAG_BITS-1:0]   o_tag,
  output logic [31:0]           o_data,
  input  logic                  i_we,
  input  logic [TAG_BITS-1:0]   i_wtag,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_be,
  input  logic                  i_inval,
  input  logic                  i_flush
);
  logic [SETS-1:0]     r_valid;
  logic [TAG_BITS-1:0] r_tag [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_valid          <= '0;
    else if (i_flush) r_valid          <= '0;
    else if (i_inval) r_valid[i_index] <= 1'b0;
    else if (i_we)    r_valid[i_index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_we) r_tag[i_index] <= i_wtag;
  end

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];

  // One byte-wide array per lane so the enable mask maps onto independent writes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [SETS];
      always_ff @(posedge clk) begin
        if (i_we && i_be[gi]) r_lane[i_index] <= i_wdata[8*gi +: 8];
      end
      assign o_data[8*gi +: 8] = r_lane[i_index];
    end
  endgenerate
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache with a one-cycle FILL refill.
module data_cache import cache_pkg::*; (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDRESS_LENGTH-1:0] a,
  input  logic                      re,
  input  logic                      sw,
  input  logic                      sh,
  input  logic                      sb,
  input  logic [ADDRESS_LENGTH-1:0] wd,
  input  logic                      flush,
  output logic [ADDRESS_LENGTH-1:0] rd,
  output logic                      stall,
  output logic [ADDRESS_LENGTH-1:0] mem_a,
  output logic [ADDRESS_LENGTH-1:0] mem_wd,
  output logic                      mem_sw,
  output logic                      mem_sh,
  output logic                      mem_sb,
  input  logic [ADDRESS_LENGTH-1:0] mem_rd
);
  cache_state_t          r_state;
  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [TAG_BITS-1:0]   w_line_tag;
  logic                  w_line_valid;
  logic [31:0]           w_line_data;
  logic                  w_hit, w_store, w_sb, w_sh, w_sw, w_misalign;
  logic                  w_we, w_inval;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;

  assign w_offset   = a[1:0];
  assign w_index    = a[INDEX_BITS+1:2];
  assign w_tag      = a[ADDRESS_LENGTH-1:INDEX_BITS+2];
  assign w_hit      = w_line_valid && (w_line_tag == w_tag);
  assign w_sb       = sb;
  assign w_sh       = sh & ~sb;
  assign w_sw       = sw & ~sb & ~sh;
  assign w_store    = sb | sh | sw;
  assign w_misalign = (w_sh & a[0]) | (w_sw & (a[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_state <= IDLE;
    else if (r_state == FILL)                r_state <= IDLE;
    else if (!w_store && re && !w_hit)       r_state <= FILL;
  end

  always_comb begin
    rd      = '0;
    stall   = 1'b0;
    mem_a   = a;
    mem_wd  = wd;
    mem_sb  = 1'b0;
    mem_sh  = 1'b0;
    mem_sw  = 1'b0;
    w_we    = 1'b0;
    w_inval = 1'b0;
    w_be    = 4'b0000;
    w_wdata = '0;
    if (r_state == FILL) begin
      mem_a = {a[ADDRESS_LENGTH-1:2], 2'b00};
      stall = 1'b1;
      if (!flush) begin
        w_we    = 1'b1;
        w_be    = 4'b1111;
        w_wdata = mem_rd;
      end
    end else begin
      if (w_hit) rd = w_line_data;
      if (w_store) begin
        mem_sb = w_sb;
        mem_sh = w_sh;
        mem_sw = w_sw;
        // Misaligned hits are dropped from the cache rather than patched.
        if (w_hit && w_misalign) begin
          w_inval = 1'b1;
        end else if (w_hit) begin
          w_we    = 1'b1;
          w_be    = lane_mask(w_sb, w_sh, w_sw, w_offset);
          w_wdata = w_sb ? {4{wd[7:0]}} : (w_sh ? {2{wd[15:0]}} : wd);
        end
      end else if (re && !w_hit) begin
        stall = 1'b1;
      end
    end
  end

  cache_store u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_index (w_index),
    .o_valid (w_line_valid),
    .o_tag   (w_line_tag),
    .o_data  (w_line_data),
    .i_we    (w_we),
    .i_wtag  (w_tag),
    .i_wdata (w_wdata),
    .i_be    (w_be),
    .i_inval (w_inval),
    .i_flush (flush)
  );
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a byte-addressed RAM model and a load-data scoreboard.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, wd = '0, rd, mem_a, mem_wd, mem_rd;
  logic        re = 1'b0, sw = 1'b0, sh = 1'b0, sb = 1'b0, flush = 1'b0;
  logic        stall, mem_sw, mem_sh, mem_sb;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram    [0:4095];
  logic [31:0] shadow [0:4095];

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .rst_n(rst_n), .a(a), .re(re), .sw(sw), .sh(sh), .sb(sb),
    .wd(wd), .flush(flush), .rd(rd), .stall(stall), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_sw(mem_sw), .mem_sh(mem_sh), .mem_sb(mem_sb),
    .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'hDEADBEEF;
    return 32'h1000_0000 + i * 32'h0001_0101;
  endfunction

  assign mem_rd = ram[mem_a[13:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
    end else if (mem_sb) ram[mem_a[13:2]][8*mem_a[1:0] +: 8]  <= mem_wd[7:0];
    else if (mem_sh)     ram[mem_a[13:2]][16*mem_a[1] +: 16] <= mem_wd[15:0];
    else if (mem_sw)     ram[mem_a[13:2]]                    <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input int exp_stall, input string tag);
    int          stalls = 0;
    logic        done = 1'b0;
    logic [31:0] e;
    exp_q.push_back(shadow[addr[13:2]]);
    a  = addr;
    re = 1'b1;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        if (stalls == 2) begin
          check({tag, " fill_mem_a"}, mem_a, {addr[31:2], 2'b00});
          check({tag, " fill_strobes"}, {29'd0, mem_sb, mem_sh, mem_sw}, 32'd0);
        end
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    e = exp_q.pop_front();
    check({tag, " completed"}, {31'd0, done}, 32'd1);
    check({tag, " rd"}, rd, e);
    check({tag, " stall_cycles"}, stalls, exp_stall);
    $display("[TB] load  %s a=%h stalls=%0d rd=%h", tag, addr, stalls, rd);
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  // strb = {sb, sh, sw}; the bench resolves priority itself.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] strb, input logic with_re, input string tag);
    logic [2:0]  fwd;
    logic [31:0] w;
    int          idx;
    fwd = strb[2] ? 3'b100 : (strb[1] ? 3'b010 : (strb[0] ? 3'b001 : 3'b000));
    a  = addr; wd = data; re = with_re;
    sb = strb[2]; sh = strb[1]; sw = strb[0];
    @(negedge clk);
    check({tag, " stall"}, {31'd0, stall}, 32'd0);
    check({tag, " mem_a"}, mem_a, addr);
    check({tag, " mem_wd"}, mem_wd, data);
    check({tag, " strobes"}, {29'd0, mem_sb, mem_sh, mem_sw}, {29'd0, fwd});
    $display("[TB] store %s a=%h wd=%h strobes=%b", tag, addr, data, {mem_sb, mem_sh, mem_sw});
    idx = int'(addr[13:2]);
    w = shadow[idx];
    if (fwd[2])      w[8*addr[1:0] +: 8]  = data[7:0];
    else if (fwd[1]) w[16*addr[1] +: 16] = data[15:0];
    else             w = data;
    shadow[idx] = w;
    @(posedge clk); #1;
    sb = 1'b0; sh = 1'b0; sw = 1'b0; re = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
    a  = 32'h1234_5678;
    wd = 32'h0BAD_F00D;
    repeat (3) @(posedge clk);
    #1;
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset rd", rd, 32'd0);
    check("reset strobes", {29'd0, mem_sb, mem_sh, mem_sw}, 32'd0);
    check("reset mem_a", mem_a, 32'h1234_5678);
    check("reset mem_wd", mem_wd, 32'h0BAD_F00D);
    $display("[TB] reset checked");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(32'h0001_0000, 2, "miss_first");
    do_load(32'h0001_0000, 0, "hit_repeat");

    do_load(32'h0001_0004, 2, "miss_w1");
    do_store(32'h0001_0006, 32'h0000_00AA, 3'b100, 1'b0, "sb_hit");
    check("ram sb word", ram[1], 32'h10AA_0101);
    do_load(32'h0001_0004, 0, "hit_after_sb");
    do_store(32'h0001_0006, 32'h0000_1234, 3'b011, 1'b0, "sh_over_sw");
    do_load(32'h0001_0004, 0, "hit_after_sh");

    do_load(32'h0001_0400, 2, "conflict_miss");
    do_load(32'h0001_0000, 2, "conflict_reload");

    do_store(32'h0001_0001, 32'hCAFE_F00D, 3'b001, 1'b0, "sw_misaligned");
    do_load(32'h0001_0000, 2, "after_misaligned");

    do_store(32'h0001_0000, 32'h1122_3344, 3'b001, 1'b1, "sw_with_re");
    do_load(32'h0001_0000, 0, "hit_after_sw");

    // Flush during the refill cycle.
    a = 32'h0001_0800; re = 1'b1;
    @(negedge clk);
    check("flushfill miss_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flushfill fill_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    $display("[TB] flush during FILL");
    do_load(32'h0001_0800, 2, "after_flushfill");

    flush = 1'b1;
    do_store(32'h0001_0004, 32'h0000_0077, 3'b100, 1'b0, "sb_with_flush");
    flush = 1'b0;
    do_load(32'h0001_0000, 2, "post_flush_w0");
    do_load(32'h0001_0004, 2, "post_flush_w1");

    do_store(32'h0001_1000, 32'h0000_005C, 3'b100, 1'b0, "sb_miss");
    do_load(32'h0001_0000, 0, "untouched_by_miss");
    do_load(32'h0001_1000, 2, "load_store_miss");

    // Reset pulse inside the refill cycle, released before the next edge.
    a = 32'h0001_0C00; re = 1'b1;
    @(negedge clk);
    check("rstfill miss_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; re = 1'b0;
    #1;
    check("rstfill stall", {31'd0, stall}, 32'd0);
    check("rstfill strobes", {29'd0, mem_sb, mem_sh, mem_sw}, 32'd0);
    #2;
    rst_n = 1'b1;
    $display("[TB] reset during FILL");
    do_load(32'h0001_0C00, 2, "after_rstfill");
    do_load(32'h0001_0004, 2, "post_reset_w1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store stage and the byte-addressed data RAM. The cache absorbs loads with a single-word line store and stalls the pipeline for a two-cycle refill on a miss. Stores pass straight through to the RAM using the same sb/sh/sw strobe encoding, and update any cached copy. The RAM read port is combinational, so a refill needs only one FILL cycle.

## Interface
- ADDRESS_LENGTH, 32, byte-address and data width.
- SETS, 256, number of lines; power of two; one 32-bit word per line.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  32  CPU byte address.
- re  in  1  load request.
- sw / sh / sb  in  1 each  store word / half / byte strobes.
- wd  in  32  store data, right-aligned as the RAM expects.
- flush  in  1  invalidate all lines.
- rd  out  32  load data; the aligned word containing `a`.
- stall  out  1  hold the CPU request and pipeline.
- mem_a  out  32  RAM address.
- mem_wd  out  32  RAM write data.
- mem_sw / mem_sh / mem_sb  out  1 each  RAM store strobes.
- mem_rd  in  32  RAM combinational read data.

## Operation
- Address split: offset = a[1:0], index = a[$clog2(SETS)+1:2], tag = remaining upper bits.
- The per-line valid bit and tag form the hit condition: hit = valid[index] && tag matches.
- State machine has two states, IDLE and FILL.
- **Load (IDLE):**
  - On a hit, rd = cached word and stall = 0.
  - On a miss, stall = 1 and the next state is FILL.
- **FILL:**
  - mem_a = {a[31:2], 2'b00}; stall = 1; all mem strobes are 0.
  - At the clock edge, write mem_rd, the tag, and valid = 1 into the line, then go to IDLE.
  - The CPU holds a/re, so the following cycle hits.
- **Store (IDLE):**
  - Any strobe drives mem_a = a, mem_wd = wd, and mem_* strobes identical to the inputs in the same cycle, with stall = 0.
  - Strobe priority is sb > sh > sw; only the highest-priority strobe is forwarded.
  - On a hit, update cached bytes at the same edge:
    - sb updates lane a[1:0] with wd[7:0].
    - sh updates lanes a[1]*2 and +1 with wd[15:0].
    - sw updates all lanes.
  - Store miss: cache unchanged.
- **Misaligned store hit:** sh with a[0]=1, or sw with a[1:0]≠0. The RAM still performs the store, but the line at index is invalidated, not patched.
- **Load and store in the same cycle:** the store wins and re is ignored that cycle.
- **Flush:** clears all valid bits at the edge. A flush in FILL aborts the refill (no line write) and returns to IDLE. A flush concurrent with an IDLE store still forwards the store.
- rd = 0 whenever there is no hit or the state is FILL.

## Timing
- Reset values:
  - state = IDLE; all valid = 0.
  - stall = 0, rd = 0, mem strobes = 0.
  - mem_a = a, mem_wd = wd (combinational pass-through).
- Reset asserted mid-FILL returns to IDLE with the line unwritten. Tag and data arrays need no reset.
- Load hit: zero-cycle latency, rd is combinational in the request cycle.
- Load miss: stall is high in the miss cycle and the FILL cycle (2 cycles); data is valid in cycle 3.
- Store: zero stall; the RAM and cache update at the same edge.
- Back-to-back misses to different indices each cost 2 stall cycles; no request queueing.

## Structure
- Package `cache_pkg`:
  - `cache_state_t` enum {IDLE, FILL}.
  - INDEX_BITS and TAG_BITS localparams derived from SETS and ADDRESS_LENGTH.
  - Lane-mask function computing a 4-bit byte-enable from sb/sh/sw and offset.
- Sub-module `cache_store`: holds the valid, tag, and data arrays.
  - One combinational read port.
  - One write port with a byte-enable mask.
  - Per-line invalidate and a global flush.
  - Valid bits are reset by rst_n.
- The top level holds the FSM, hit logic, and memory-side muxing.

## Test plan
- Reset, then load a=0x00010000 with the RAM holding 0xDEADBEEF → stall=1 for 2 cycles, mem_a=0x00010000 during FILL, rd=0xDEADBEEF in cycle 3 with stall=0; a repeat load hits with no stall.
- After filling 0x00010004, sb a=0x00010006 wd=0x000000AA → mem_sb=1 the same cycle; a subsequent load reads RAM and cache as 0x..AA.. in byte 2 with no stall.
- Conflict: fill 0x00010000, then load 0x00010400 (same index, different tag) → miss, 2-cycle stall, then a reload of 0x00010000 misses again.
- Misaligned sw a=0x00010001 to a cached line → line invalidated, and the next load of 0x00010000 stalls and returns the RAM contents.
- Assert flush (or rst_n=0) during the FILL cycle → no line written, state IDLE; the held load re-misses and completes correctly.
- re=1 with sw=1 together → store forwarded, stall=0, no FILL entered.
